exec_issue_stage: RTL

// - Issue stage feeding exec_unit. Decodes one RV32I integer instruction per cycle and reads its

---
 rtl/exec_issue_if.sv | 34 +++
 rtl/exec_issue_stage.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/exec_issue_if.sv
// Handshake bundle between the fetch side, the exec_issue_stage and exec_unit.
// slave = the issue stage's view, master = the surrounding pipeline's view.
interface exec_issue_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [XLEN-1:0]      out_rs1;
  logic [XLEN-1:0]      out_rs2;
  logic [XLEN-1:0]      out_imm;
  logic [5:0]           out_params;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 out_rd_we;
  logic                 out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_imm,
           out_params, out_rd, out_rd_we, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_imm,
           out_params, out_rd, out_rd_we, out_illegal
  );
endinterface

// File: rtl/exec_issue_stage.sv
// RV32I integer issue stage: decode, operand read, and a 2-entry (main + skid) output buffer.
// Optional writeback bypass on the operand read is enabled by defining EXEC_ISSUE_BYPASS_EN.
module exec_issue_stage #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  exec_issue_if.slave          bus,
  output logic [REG_IDX_W-1:0] rs1_idx,
  output logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic                 wb_we,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic SEL1_REG = 1'b0;
  localparam logic SEL1_PC  = 1'b1;
  localparam logic SEL2_REG = 1'b0;
  localparam logic SEL2_IMM = 1'b1;
  localparam logic [3:0] EXEC_ADD = 4'b0000;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      imm;
    logic [5:0]           params;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_we;
    logic                 illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  entry_t          dec;

  assign opcode  = bus.in_instr[6:0];
  assign funct3  = bus.in_instr[14:12];
  // LUI has no rs1; its field holds immediate bits, so the read address is forced to x0.
  assign rs1_idx = (opcode == OPC_LUI) ? '0 : bus.in_instr[19:15];
  assign rs2_idx = bus.in_instr[24:20];

`ifdef EXEC_ISSUE_BYPASS_EN
  assign rs1_val = (wb_we && (wb_rd != '0) && (wb_rd == rs1_idx)) ? wb_data : rs1_data;
  assign rs2_val = (wb_we && (wb_rd != '0) && (wb_rd == rs2_idx)) ? wb_data : rs2_data;
`else
  logic wb_unused;
  assign wb_unused = ^{wb_we, wb_rd, wb_data};
  assign rs1_val   = rs1_data;
  assign rs2_val   = rs2_data;
`endif

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rs1     = rs1_val;
    dec.rs2     = rs2_val;
    dec.rd      = bus.in_instr[11:7];
    dec.rd_we   = (bus.in_instr[11:7] != '0);
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.params = {SEL1_REG, SEL2_REG, bus.in_instr[30], funct3};
        dec.imm    = '0;
      end
      OPC_OP_IMM: begin
        // Only SRAI uses instr[30]; ADDI with a negative immediate must never become SUB.
        dec.params = {SEL1_REG, SEL2_IMM, (funct3 == 3'b101) & bus.in_instr[30], funct3};
        dec.imm    = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
      end
      OPC_LUI: begin
        dec.params = {SEL1_REG, SEL2_IMM, EXEC_ADD};
        dec.imm    = {bus.in_instr[31:12], 12'b0};
        dec.rs1    = '0;
      end
      OPC_AUIPC: begin
        dec.params = {SEL1_PC, SEL2_IMM, EXEC_ADD};
        dec.imm    = {bus.in_instr[31:12], 12'b0};
      end
      default: begin
        dec.params  = {SEL1_REG, SEL2_IMM, EXEC_ADD};
        dec.imm     = '0;
        dec.rd_we   = 1'b0;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Handshake: a beat moves on either side only in a cycle where valid && ready are both 1
  // at the rising edge; valid never depends on ready, and a presented entry is held stable
  // until it is taken.
  entry_t main_q, skid_q;
  logic   main_valid, skid_valid;
  logic   accept, drain;

  assign accept = bus.in_valid && bus.in_ready && !flush;
  assign drain  = main_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      // Main slot frees up: refill from skid first to keep FIFO order.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        if (accept) begin
          skid_q <= dec;
        end
        skid_valid <= accept;
      end else begin
        if (accept) begin
          main_q <= dec;
        end
        main_valid <= accept;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready    = !skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_pc      = main_q.pc;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_params  = main_q.params;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rd_we   = main_q.rd_we;
  assign bus.out_illegal = main_q.illegal;

endmodule
